// File: rtl/sa_fifo_pkg.sv
// Shared sizing constants for the 64x64 RAM-backed valid/ready FIFO.
package sa_fifo_pkg;
    localparam int DW        = 64;
    localparam int AW        = 6;
    localparam int RAM_DEPTH = 64;
    localparam int OUT_DEPTH = 2;
    localparam int CNT_W     = 7;
endpackage

// File: rtl/sa_ram_rws_64x64.sv
// 64x64 two-port RAM model: one write port, one read port with a registered
// read address, so dout reflects the address captured at the last re edge.
module sa_ram_rws_64x64
    import sa_fifo_pkg::*;
(
    input  logic          clk,
    input  logic [AW-1:0] ra,
    input  logic          re,
    output logic [DW-1:0] dout,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [DW-1:0] di,
    input  logic [31:0]   pwrbus_ram_pd
);
    logic [DW-1:0] mem [RAM_DEPTH];
    logic [AW-1:0] ra_q;
    logic          pwrbus_unused;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= di;
        end
        if (re) begin
            ra_q <= ra;
        end
    end

    assign dout          = mem[ra_q];
    assign pwrbus_unused = ^pwrbus_ram_pd;
endmodule

// File: rtl/sa_fifo_ctrl_64x64.sv
// Valid/ready FIFO over sa_ram_rws_64x64; a 2-entry output buffer hides the
// RAM read latency so the read side streams one word per cycle.
module sa_fifo_ctrl_64x64 #(
    parameter int DW = sa_fifo_pkg::DW,
    parameter int AW = sa_fifo_pkg::AW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_pvld,
    output logic                          wr_prdy,
    input  logic [DW-1:0]                 wr_pd,
    output logic                          rd_pvld,
    input  logic                          rd_prdy,
    output logic [DW-1:0]                 rd_pd,
    output logic [sa_fifo_pkg::CNT_W-1:0] fifo_cnt,
    input  logic [31:0]                   pwrbus_ram_pd
);
    import sa_fifo_pkg::*;

    // Handshake: a word moves on an edge where pvld & prdy are both high;
    // pvld never depends on prdy, and rd_pd is held while rd_pvld & ~rd_prdy.
    localparam logic [CNT_W-1:0] RAM_FULL = CNT_W'(RAM_DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] ram_cnt;
    logic             inflight;
    logic [1:0]       out_cnt;
    logic [DW-1:0]    out_buf [OUT_DEPTH];
    logic [DW-1:0]    ram_dout;

    logic             push;
    logic             pop;
    logic             re;
    logic [2:0]       out_commit;
    logic [CNT_W-1:0] ram_cnt_nxt;
    logic             inflight_nxt;
    logic [1:0]       out_cnt_nxt;
    logic [CNT_W-1:0] fifo_cnt_nxt;

    assign wr_prdy = ~rst & (ram_cnt != RAM_FULL);
    assign push    = wr_pvld & wr_prdy;
    assign rd_pvld = (out_cnt != 2'd0);
    assign rd_pd   = out_buf[0];
    assign pop     = rd_pvld & rd_prdy;

    // Words already owed to the output buffer once this cycle's pop leaves.
    assign out_commit = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign re         = ~rst & (ram_cnt != '0) & (out_commit < 3'd2);

    always_comb begin
        ram_cnt_nxt  = ram_cnt + CNT_W'(push) - CNT_W'(re);
        inflight_nxt = re;
        out_cnt_nxt  = out_cnt + {1'b0, inflight} - {1'b0, pop};
        fifo_cnt_nxt = ram_cnt_nxt + CNT_W'(inflight_nxt) + CNT_W'(out_cnt_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            inflight   <= 1'b0;
            out_cnt    <= '0;
            fifo_cnt   <= '0;
            out_buf[0] <= '0;
            out_buf[1] <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (re) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            ram_cnt  <= ram_cnt_nxt;
            inflight <= inflight_nxt;
            out_cnt  <= out_cnt_nxt;
            fifo_cnt <= fifo_cnt_nxt;
            // A capture never coincides with out_cnt==2, since issue is gated on room.
            if (pop) begin
                if (out_cnt == 2'd2) begin
                    out_buf[0] <= out_buf[1];
                end else if (inflight) begin
                    out_buf[0] <= ram_dout;
                end
            end else if (inflight) begin
                out_buf[out_cnt[0]] <= ram_dout;
            end
        end
    end

    sa_ram_rws_64x64 u_ram (
        .clk           (clk),
        .ra            (rd_ptr),
        .re            (re),
        .dout          (ram_dout),
        .wa            (wr_ptr),
        .we            (push),
        .di            (wr_pd),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );
endmodule

// File: tb/tb_sa_fifo_ctrl_64x64.sv
// Directed bench for sa_fifo_ctrl_64x64: cycle table for basic latency, then
// hand sequences for fill, streaming, back-pressure, reset and full-boundary cases.
module tb_sa_fifo_ctrl_64x64;
  logic        clk;
  logic        rst;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [63:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [63:0] rd_pd;
  logic [6:0]  fifo_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;
  int n_acc = 0;
  logic [63:0] exp_q[$];
  logic        hold_prev = 1'b0;
  logic [63:0] hold_pd = '0;

  typedef struct {
    logic        rst;
    logic        wr_pvld;
    logic [63:0] wr_pd;
    logic        rd_prdy;
    logic        e_wr_prdy;
    logic        e_rd_pvld;
    logic [63:0] e_rd_pd;
    logic [6:0]  e_cnt;
  } vec_t;
  vec_t vt [12];

  sa_fifo_ctrl_64x64 dut (
    .clk           (clk),
    .rst           (rst),
    .wr_pvld       (wr_pvld),
    .wr_prdy       (wr_prdy),
    .wr_pd         (wr_pd),
    .rd_pvld       (rd_pvld),
    .rd_prdy       (rd_prdy),
    .rd_pd         (rd_pd),
    .fifo_cnt      (fifo_cnt),
    .pwrbus_ram_pd (32'h0)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [63:0] pd, input logic pr);
    wr_pvld = pv;
    wr_pd   = pd;
    rd_prdy = pr;
  endtask

  // scoreboard: called at the negedge, models what the next posedge does
  task automatic score();
    logic [63:0] exp_v;
    if (hold_prev) begin
      check("hold_vld", rd_pvld, 1);
      check("hold_pd", rd_pd, hold_pd);
    end
    if (rd_pvld && rd_prdy) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected: got rd_pd %0h, required no pop (queue empty)", rd_pd);
      end else begin
        exp_v = exp_q.pop_front();
        check("pop_data", rd_pd, exp_v);
      end
    end
    if (wr_pvld && wr_prdy) begin
      exp_q.push_back(wr_pd);
      n_acc++;
    end
    hold_prev = rd_pvld && !rd_prdy;
    hold_pd   = rd_pd;
  endtask

  task automatic cyc(input logic pv, input logic [63:0] pd, input logic pr);
    drive(pv, pd, pr);
    @(negedge clk);
    score();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drive(1'b0, 64'd0, 1'b0);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    hold_prev = 1'b0;
    n_pop = 0;
    n_acc = 0;
  endtask

  task automatic fill(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, base + 64'(i), 1'b0);
  endtask

  task automatic drain(input logic toggle);
    for (int k = 0; k < 400 && exp_q.size() != 0; k++)
      cyc(1'b0, 64'd0, toggle ? ~k[0] : 1'b1);
    // allow the final pop's edge to settle before checking emptiness
    check("drain_empty", 64'(exp_q.size()), 0);
    check("drain_cnt", fifo_cnt, 0);
  endtask

  initial begin
    int bubbles;
    rst = 1'b1;
    drive(1'b0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // test 1: single word latency, then two words with back-pressure
    vt[0]  = '{1'b1, 1'b0, 64'h0,                  1'b0, 1'b0, 1'b0, 64'h0,                  7'd0};
    vt[1]  = '{1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1, 1'b0, 64'h0,                  7'd0};
    vt[2]  = '{1'b0, 1'b0, 64'h0,                  1'b1, 1'b1, 1'b0, 64'h0,                  7'd1};
    vt[3]  = '{1'b0, 1'b0, 64'h0,                  1'b1, 1'b1, 1'b0, 64'h0,                  7'd1};
    vt[4]  = '{1'b0, 1'b0, 64'h0,                  1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 7'd1};
    vt[5]  = '{1'b0, 1'b1, 64'h1111,               1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 7'd0};
    vt[6]  = '{1'b0, 1'b1, 64'h2222,               1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 7'd1};
    vt[7]  = '{1'b0, 1'b0, 64'h0,                  1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 7'd2};
    vt[8]  = '{1'b0, 1'b0, 64'h0,                  1'b0, 1'b1, 1'b1, 64'h1111,               7'd2};
    vt[9]  = '{1'b0, 1'b0, 64'h0,                  1'b1, 1'b1, 1'b1, 64'h1111,               7'd2};
    vt[10] = '{1'b0, 1'b0, 64'h0,                  1'b1, 1'b1, 1'b1, 64'h2222,               7'd1};
    vt[11] = '{1'b0, 1'b0, 64'h0,                  1'b0, 1'b1, 1'b0, 64'h2222,               7'd0};
    for (int i = 0; i < 12; i++) begin
      rst = vt[i].rst;
      drive(vt[i].wr_pvld, vt[i].wr_pd, vt[i].rd_prdy);
      @(negedge clk);
      check($sformatf("t1_wr_prdy[%0d]", i), wr_prdy, vt[i].e_wr_prdy);
      check($sformatf("t1_rd_pvld[%0d]", i), rd_pvld, vt[i].e_rd_pvld);
      check($sformatf("t1_rd_pd[%0d]", i), rd_pd, vt[i].e_rd_pd);
      check($sformatf("t1_cnt[%0d]", i), fifo_cnt, vt[i].e_cnt);
      if (!rst) score();
      @(posedge clk);
      #1;
    end

    // test 2: fill with 70 offered words, exactly 66 fit, then drain
    do_reset(2);
    fill(64'd0, 70);
    check("t2_accepted", n_acc, 66);
    drive(1'b0, 64'd0, 1'b1);
    @(negedge clk);
    check("t2_full_wr_prdy", wr_prdy, 0);
    check("t2_full_cnt", fifo_cnt, 66);
    score();
    @(posedge clk);
    #1;
    drive(1'b0, 64'd0, 1'b1);
    @(negedge clk);
    check("t2_wr_prdy_back", wr_prdy, 1);
    score();
    @(posedge clk);
    #1;
    drain(1'b0);
    check("t2_pops", n_pop, 66);

    // test 3: full-rate streaming through several pointer wraps
    do_reset(2);
    bubbles = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 64'h3000 + 64'(i), 1'b1);
      @(negedge clk);
      if (i >= 3 && !rd_pvld) bubbles++;
      if (i == 100) check("t3_steady_cnt", fifo_cnt, 3);
      score();
      @(posedge clk);
      #1;
    end
    check("t3_bubbles", bubbles, 0);
    drain(1'b0);
    check("t3_pops", n_pop, 200);

    // test 4: full FIFO drained with toggling ready
    do_reset(2);
    fill(64'h4000, 66);
    check("t4_full_cnt", fifo_cnt, 66);
    drain(1'b1);
    check("t4_pops", n_pop, 66);

    // test 5: reset discards queued data
    do_reset(2);
    fill(64'h5000, 10);
    check("t5_queued_cnt", fifo_cnt, 10);
    rst = 1'b1;
    drive(1'b0, 64'd0, 1'b0);
    @(negedge clk);
    check("t5_rst_wr_prdy", wr_prdy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    hold_prev = 1'b0;
    n_pop = 0;
    drive(1'b0, 64'd0, 1'b0);
    @(negedge clk);
    check("t5_post_cnt", fifo_cnt, 0);
    check("t5_post_vld", rd_pvld, 0);
    check("t5_post_pd", rd_pd, 0);
    @(posedge clk);
    #1;
    cyc(1'b1, 64'h5A5A, 1'b0);
    drain(1'b0);
    check("t5_pops", n_pop, 1);

    // test 6: single pop from completely full, slot reuse on the next cycle
    do_reset(2);
    fill(64'h6000, 66);
    drive(1'b0, 64'd0, 1'b0);
    @(negedge clk);
    check("t6_full_cnt", fifo_cnt, 66);
    check("t6_full_wr_prdy", wr_prdy, 0);
    score();
    @(posedge clk);
    #1;
    drive(1'b0, 64'd0, 1'b1);
    @(negedge clk);
    check("t6_pulse_wr_prdy", wr_prdy, 0);
    score();
    @(posedge clk);
    #1;
    drive(1'b1, 64'hC0FF_EE00, 1'b0);
    @(negedge clk);
    check("t6_next_wr_prdy", wr_prdy, 1);
    check("t6_mid_cnt", fifo_cnt, 65);
    score();
    @(posedge clk);
    #1;
    drive(1'b0, 64'd0, 1'b0);
    @(negedge clk);
    check("t6_refull_cnt", fifo_cnt, 66);
    score();
    @(posedge clk);
    #1;
    drain(1'b0);
    check("t6_pops", n_pop, 67);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
